// File: rtl/sccb_master.sv
// sccb_master: SCCB/I2C master for camera-sensor register programming.
// Write = START, {dev,0}, sub-address byte(s), data, STOP.
// Read  = START, {dev,0}, sub-address byte(s), STOP, START, {dev,1}, 8 RX bits, NA, STOP.
// Every bus phase is built from quarter periods of CLK_DIV clocks.
module sccb_master #(
  parameter int CLK_DIV    = 125,
  parameter int ADDR_BYTES = 1,
  parameter int CHECK_ACK  = 0,
  parameter int IDLE_GAP   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    rw,
  input  logic [6:0]              dev_addr,
  input  logic [8*ADDR_BYTES-1:0] reg_addr,
  input  logic [7:0]              wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    nack,
  output logic [7:0]              rdata,
  output logic                    scl,
  output logic                    sda_oe,
  input  logic                    sda_in
);
  localparam int QCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NB  = ADDR_BYTES + 2;
  localparam int BW  = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE, START, TX_BIT, TX_ACK, RX_BIT, RX_NA, STOP, GAP
  } state_t;

  state_t                  state;
  logic [QCW-1:0]          qcnt;
  logic [7:0]              q;        // quarter index inside the current phase
  logic [2:0]              bcnt;
  logic [BW-1:0]           bidx;     // index of the byte being transmitted
  logic [7:0]              sh;       // TX shift-out / RX shift-in
  logic                    phase2;   // second (read) phase of a read
  logic                    rw_l;
  logic [6:0]              dev_l;
  logic [8*ADDR_BYTES-1:0] reg_l;
  logic [7:0]              wdata_l;

  logic                    tick, sample, ack_bad;
  logic [NB-1:0][7:0]      seq;
  logic [BW-1:0]           last_idx;
  logic [7:0]              nxt_byte;

  assign tick    = (qcnt == QCW'(CLK_DIV - 1));
  // SDA is sampled on the first clock of the fourth quarter of a bit cell.
  assign sample  = (qcnt == '0) && (q == 8'd3);
  assign ack_bad = (CHECK_ACK != 0) && (nack || (sample && sda_in));

  // Byte list for the current phase: device byte, sub-address MSB first, data.
  always_comb begin
    seq = '0;
    seq[0] = {dev_l, phase2};
    for (int i = 0; i < ADDR_BYTES; i++)
      seq[i+1] = reg_l[8*(ADDR_BYTES-1-i) +: 8];
    seq[NB-1] = wdata_l;
    last_idx = phase2 ? '0 : (rw_l ? BW'(ADDR_BYTES) : BW'(ADDR_BYTES + 1));
    nxt_byte = seq[BW'(bidx + 1'b1)];
  end

  // Bus sequencer: all pin and status outputs are registered at quarter boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      qcnt    <= '0;
      q       <= '0;
      bcnt    <= '0;
      bidx    <= '0;
      sh      <= '0;
      phase2  <= 1'b0;
      rw_l    <= 1'b0;
      dev_l   <= '0;
      reg_l   <= '0;
      wdata_l <= '0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      if (busy) qcnt <= tick ? '0 : qcnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          dev_l   <= dev_addr;
          rw_l    <= rw;
          reg_l   <= reg_addr;
          wdata_l <= wdata;
          busy    <= 1'b1;
          nack    <= 1'b0;
          phase2  <= 1'b0;
          qcnt    <= '0;
          q       <= '0;
          scl     <= 1'b1;
          sda_oe  <= 1'b0;
          state   <= START;
        end
        START: if (tick) begin
          if (q == 8'd0) begin
            q      <= 8'd1;
            sda_oe <= 1'b1;
          end else begin
            q     <= '0;
            scl   <= 1'b0;
            bcnt  <= '0;
            bidx  <= '0;
            sh    <= seq[0];
            state <= TX_BIT;
          end
        end
        TX_BIT, TX_ACK, RX_BIT, RX_NA: begin
          if (sample && state == RX_BIT) sh <= {sh[6:0], sda_in};
          if (sample && state == TX_ACK && CHECK_ACK != 0 && sda_in) nack <= 1'b1;
          if (tick) begin
            case (q)
              8'd0: begin
                q      <= 8'd1;
                sda_oe <= (state == TX_BIT) ? ~sh[7] : 1'b0;
              end
              8'd1: begin
                q   <= 8'd2;
                scl <= 1'b1;
              end
              8'd2: q <= 8'd3;
              default: begin
                q   <= '0;
                scl <= 1'b0;
                case (state)
                  TX_BIT: begin
                    sh   <= {sh[6:0], 1'b0};
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == 3'd7) state <= TX_ACK;
                  end
                  TX_ACK: begin
                    if (ack_bad) begin
                      sda_oe <= 1'b1;
                      state  <= STOP;
                    end else if (bidx != last_idx) begin
                      bidx  <= bidx + 1'b1;
                      sh    <= nxt_byte;
                      bcnt  <= '0;
                      state <= TX_BIT;
                    end else if (phase2) begin
                      bcnt  <= '0;
                      state <= RX_BIT;
                    end else begin
                      sda_oe <= 1'b1;
                      state  <= STOP;
                    end
                  end
                  RX_BIT: begin
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == 3'd7) state <= RX_NA;
                  end
                  default: begin
                    sda_oe <= 1'b1;
                    state  <= STOP;
                  end
                endcase
              end
            endcase
          end
        end
        STOP: if (tick) begin
          if (q == 8'd0) begin
            q   <= 8'd1;
            scl <= 1'b1;
          end else if (q == 8'd1) begin
            q      <= 8'd2;
            sda_oe <= 1'b0;
          end else begin
            q <= '0;
            // The STOP between the two read phases flows straight into a new START.
            if (rw_l && !phase2 && !nack) begin
              phase2 <= 1'b1;
              state  <= START;
            end else begin
              done  <= 1'b1;
              state <= GAP;
              if (rw_l && !nack) rdata <= sh;
            end
          end
        end
        GAP: if (tick) begin
          if (q == 8'(IDLE_GAP - 1)) begin
            q     <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            q <= q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: three masters share one wired-AND bus and one slave model.
// u0: 1-byte sub-address, no ACK check; u1: 2-byte sub-address; u2: ACK check.
module tb_sccb_master;
  typedef struct {
    int              sel;
    logic            rw;
    logic [6:0]      dev;
    logic [15:0]     ra;
    logic [7:0]      wd;
    logic            nm;   // slave leaves the device-byte ACK high
    logic [7:0]      rb;   // byte the slave returns on reads
    int              lat;
    logic            nk;
    logic [7:0]      rd;
    int              nb;
    logic [0:4][7:0] b;
    int              ns;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  st = '0;
  logic        rw = 1'b0;
  logic [6:0]  dev = '0;
  logic [15:0] ra = '0;
  logic [7:0]  wd = '0;
  logic [2:0]  busy_v, done_v, nack_v, scl_v, oe_v;
  logic [7:0]  rd0, rd1, rd2;
  logic        sl = 1'b1;
  logic        scl_bus, sda_bus;

  logic        nack_mode = 1'b0;
  logic [7:0]  rbyte = '0;
  logic [7:0]  got[$];
  int          starts = 0, na_cnt = 0;
  logic        na_oe_last = 1'b0;
  int          cyc = 0, t0 = 0;
  int          nvec = 0, nerr = 0;
  vec_t        vecs[8];

  assign scl_bus = &scl_v;
  assign sda_bus = ~(|oe_v) & sl;

  sccb_master #(.CLK_DIV(4), .ADDR_BYTES(1), .CHECK_ACK(0), .IDLE_GAP(4)) u0 (
    .clk(clk), .reset(reset), .start(st[0]), .rw(rw), .dev_addr(dev), .reg_addr(ra[7:0]),
    .wdata(wd), .busy(busy_v[0]), .done(done_v[0]), .nack(nack_v[0]), .rdata(rd0),
    .scl(scl_v[0]), .sda_oe(oe_v[0]), .sda_in(sda_bus));
  sccb_master #(.CLK_DIV(4), .ADDR_BYTES(2), .CHECK_ACK(0), .IDLE_GAP(4)) u1 (
    .clk(clk), .reset(reset), .start(st[1]), .rw(rw), .dev_addr(dev), .reg_addr(ra),
    .wdata(wd), .busy(busy_v[1]), .done(done_v[1]), .nack(nack_v[1]), .rdata(rd1),
    .scl(scl_v[1]), .sda_oe(oe_v[1]), .sda_in(sda_bus));
  sccb_master #(.CLK_DIV(4), .ADDR_BYTES(1), .CHECK_ACK(1), .IDLE_GAP(4)) u2 (
    .clk(clk), .reset(reset), .start(st[2]), .rw(rw), .dev_addr(dev), .reg_addr(ra[7:0]),
    .wdata(wd), .busy(busy_v[2]), .done(done_v[2]), .nack(nack_v[2]), .rdata(rd2),
    .scl(scl_v[2]), .sda_oe(oe_v[2]), .sda_in(sda_bus));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Slave + bus monitor: records START conditions and 9-bit frames, drives ACK/read data.
  initial begin
    int bitc, bytec;
    logic rdm, p_scl, p_sda;
    logic [8:0] frame;
    bitc = 0; bytec = 0; rdm = 1'b0; p_scl = 1'b1; p_sda = 1'b1; frame = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bitc = 0; bytec = 0; rdm = 1'b0; sl = 1'b1; p_scl = 1'b1; p_sda = 1'b1;
      end else begin
        if (scl_bus && p_scl && p_sda && !sda_bus) begin
          starts++; bitc = 0; bytec = 0; rdm = 1'b0;
        end else if (scl_bus && !p_scl) begin
          if (rdm && bytec == 1 && bitc == 8) begin na_cnt++; na_oe_last = |oe_v; end
          frame = {frame[7:0], sda_bus};
          bitc++;
          if (bitc == 9) begin
            got.push_back(frame[8:1]);
            if (bytec == 0) rdm = frame[1];
            bitc = 0;
            bytec++;
          end
        end else if (!scl_bus && p_scl) begin
          sl = 1'b1;
          if (bitc == 8) begin
            if (!(rdm && bytec >= 1) && !(nack_mode && bytec == 0)) sl = 1'b0;
          end else if (rdm && bytec == 1) begin
            sl = rbyte[7-bitc];
          end
        end
        p_scl = scl_bus; p_sda = sda_bus;
      end
    end
  end

  function automatic logic [7:0] rdata_of(input int s);
    case (s)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic kick(input int s);
    @(negedge clk); st[s] = 1'b1;
    @(posedge clk); #1; st[s] = 1'b0; t0 = cyc;
  endtask

  task automatic wait_done(input int s, output int lat);
    int n = 0;
    while (!done_v[s] && n < 3000) begin @(posedge clk); #1; n++; end
    lat = cyc - t0;
    chk("done_seen", done_v[s], 1'b1);
  endtask

  task automatic wait_busy_low(input int s, output int n);
    n = 0;
    while (busy_v[s] && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run_vec(input vec_t v);
    int g0, s0, n0, lat, n;
    g0 = got.size(); s0 = starts; n0 = na_cnt;
    nack_mode = v.nm; rbyte = v.rb; rw = v.rw; dev = v.dev; ra = v.ra; wd = v.wd;
    kick(v.sel);
    wait_done(v.sel, lat);
    chk("latency", lat, v.lat);
    chk("nack", nack_v[v.sel], v.nk);
    chk("rdata", rdata_of(v.sel), v.rd);
    wait_busy_low(v.sel, n);
    chk("busy_fall", n, 16);
    chk("nbytes", got.size() - g0, v.nb);
    for (int i = 0; i < v.nb; i++)
      if (g0 + i < got.size()) chk("byte", got[g0+i], v.b[i]);
    chk("starts", starts - s0, v.ns);
    if (v.rw && !v.nk) chk("na_released", {31'(na_cnt - n0), na_oe_last}, {31'd1, 1'b0});
  endtask

  initial begin
    int lat, n;
    vecs[0] = '{0, 1'b0, 7'h21, 16'h0012, 8'h80, 1'b0, 8'h00, 452, 1'b0, 8'h00, 3,
                {8'h42, 8'h12, 8'h80, 8'h00, 8'h00}, 1};
    vecs[1] = '{0, 1'b1, 7'h21, 16'h000A, 8'h00, 1'b0, 8'h76, 616, 1'b0, 8'h76, 4,
                {8'h42, 8'h0A, 8'h43, 8'h76, 8'h00}, 2};
    vecs[2] = '{1, 1'b0, 7'h21, 16'h3008, 8'h82, 1'b0, 8'h00, 596, 1'b0, 8'h00, 4,
                {8'h42, 8'h30, 8'h08, 8'h82, 8'h00}, 1};
    vecs[3] = '{2, 1'b0, 7'h21, 16'h0012, 8'h80, 1'b1, 8'h00, 164, 1'b1, 8'h00, 1,
                {8'h42, 8'h00, 8'h00, 8'h00, 8'h00}, 1};
    vecs[4] = '{0, 1'b0, 7'h21, 16'h0012, 8'h80, 1'b1, 8'h00, 452, 1'b0, 8'h76, 3,
                {8'h42, 8'h12, 8'h80, 8'h00, 8'h00}, 1};
    vecs[5] = '{2, 1'b1, 7'h21, 16'h000A, 8'h00, 1'b0, 8'h5C, 616, 1'b0, 8'h5C, 4,
                {8'h42, 8'h0A, 8'h43, 8'h5C, 8'h00}, 2};
    vecs[6] = '{2, 1'b1, 7'h21, 16'h000A, 8'h00, 1'b1, 8'hA5, 164, 1'b1, 8'h5C, 1,
                {8'h42, 8'h00, 8'h00, 8'h00, 8'h00}, 1};
    vecs[7] = '{1, 1'b1, 7'h21, 16'h1234, 8'h00, 1'b0, 8'hA5, 760, 1'b0, 8'hA5, 5,
                {8'h42, 8'h12, 8'h34, 8'h43, 8'hA5}, 2};

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_scl", scl_v, 3'b111);
    chk("rst_oe", oe_v, 3'b000);
    chk("rst_busy", busy_v, 3'b000);
    chk("rst_done_nack", {done_v, nack_v}, 6'b0);
    chk("rst_rdata", {rd0, rd1, rd2}, 24'h0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // start while busy is ignored; start held through GAP is taken on the first IDLE cycle
    nack_mode = 1'b1; rw = 1'b0; ra = 16'h0012; wd = 8'h80;
    kick(2);
    repeat (40) @(posedge clk);
    #1 st[2] = 1'b1;
    @(posedge clk); #1 st[2] = 1'b0;
    wait_done(2, lat);
    chk("ign_latency", lat, 164);
    chk("ign_nack", nack_v[2], 1'b1);
    st[2] = 1'b1; nack_mode = 1'b0;
    wait_busy_low(2, n);
    chk("held_gap", n, 16);
    @(posedge clk); #1;
    chk("held_busy", busy_v[2], 1'b1);
    chk("held_nack_clr", nack_v[2], 1'b0);
    t0 = cyc; st[2] = 1'b0;
    wait_done(2, lat);
    chk("held_latency", lat, 452);
    chk("held_nack", nack_v[2], 1'b0);
    wait_busy_low(2, n);

    // reset mid-byte, then a clean write
    rw = 1'b0; dev = 7'h21; ra = 16'h0012; wd = 8'h80;
    kick(0);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_scl", scl_v[0], 1'b1);
    chk("mid_rst_oe", oe_v[0], 1'b0);
    chk("mid_rst_busy", busy_v[0], 1'b0);
    chk("mid_rst_rdata", rd0, 8'h00);
    repeat (4) @(posedge clk);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
